// File: rtl/prim_reqack_pkg.sv
// rtl/prim_reqack_pkg.sv - state encodings shared by the req/ack data FIFO
package prim_reqack_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } src_state_e;

  typedef enum logic [1:0] {
    D_IDLE     = 2'd0,
    D_REQ      = 2'd1,
    D_WAIT_LOW = 2'd2
  } dst_state_e;

endpackage

// File: rtl/prim_reqack_fifo_mem.sv
// rtl/prim_reqack_fifo_mem.sv - Width x Depth register array, one write port, async read
module prim_reqack_fifo_mem #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  parameter int unsigned AddrW = 2
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  // Contents are deliberately left unreset; occupancy is tracked by the controller.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prim_reqack_data_fifo.sv
// rtl/prim_reqack_data_fifo.sv - req/ack handshaked data FIFO with source and destination FSMs
// Define PRIM_REQACK_DATA_FIFO_ERR_EN to compile in the sticky protocol checker on err_o.
module prim_reqack_data_fifo
  import prim_reqack_pkg::*;
#(
  parameter int unsigned Width  = 8,
  parameter int unsigned Depth  = 4,
  parameter bit          EnRzHs = 1'b0,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            src_req_i,
  output logic            src_ack_o,
  input  logic [Width-1:0] data_i,
  output logic            dst_req_o,
  input  logic            dst_ack_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0] count_o,
  output logic            err_o
);

  localparam int unsigned    PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  src_state_e      r_src_state;
  dst_state_e      r_dst_state;
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_src_ack;
  logic            r_dst_req;
  logic            w_full;
  logic            w_write;
  logic            w_pop;
  logic [Width-1:0] w_rdata;

  assign w_full  = (r_count == FullCnt);
  assign w_write = (r_src_state == S_IDLE) && src_req_i && !w_full;
  assign w_pop   = (r_dst_state == D_REQ) && dst_ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_src_state <= S_IDLE;
      r_wr_ptr    <= '0;
      r_src_ack   <= 1'b0;
    end else begin
      r_src_ack <= 1'b0;
      unique case (r_src_state)
        S_IDLE: begin
          if (w_write) begin
            r_src_state <= S_ACK;
            r_src_ack   <= 1'b1;
            r_wr_ptr    <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrW'(1);
          end
        end
        S_ACK: begin
          r_src_state <= EnRzHs ? S_WAIT_LOW : S_IDLE;
        end
        S_WAIT_LOW: begin
          if (!src_req_i) begin
            r_src_state <= S_IDLE;
          end
        end
        default: r_src_state <= S_IDLE;
      endcase
    end
  end

  // dst_req_o is asserted only from D_REQ, so the head pointer is frozen while it is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dst_state <= D_IDLE;
      r_rd_ptr    <= '0;
      r_dst_req   <= 1'b0;
    end else begin
      unique case (r_dst_state)
        D_IDLE: begin
          if (r_count != '0) begin
            r_dst_state <= D_REQ;
            r_dst_req   <= 1'b1;
          end
        end
        D_REQ: begin
          if (dst_ack_i) begin
            r_dst_state <= EnRzHs ? D_WAIT_LOW : D_IDLE;
            r_dst_req   <= 1'b0;
            r_rd_ptr    <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrW'(1);
          end
        end
        D_WAIT_LOW: begin
          if (!dst_ack_i) begin
            r_dst_state <= D_IDLE;
          end
        end
        default: begin
          r_dst_state <= D_IDLE;
          r_dst_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (w_write && !w_pop) begin
      r_count <= r_count + CntW'(1);
    end else if (!w_write && w_pop) begin
      r_count <= r_count - CntW'(1);
    end
  end

  prim_reqack_fifo_mem #(
    .Width (Width),
    .Depth (Depth),
    .AddrW (PtrW)
  ) u_mem (
    .i_clk   (clk_i),
    .i_we    (w_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

`ifdef PRIM_REQACK_DATA_FIFO_ERR_EN
  logic r_blocked;
  logic r_err;
  logic w_src_err;
  logic w_dst_err;

  // A source that abandons a request it was held off on has violated the handshake.
  assign w_src_err = r_blocked && (r_src_state == S_IDLE) && !src_req_i;
  assign w_dst_err = dst_ack_i && (r_dst_state != D_REQ) &&
                     !(EnRzHs && (r_dst_state == D_WAIT_LOW));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_blocked <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_blocked <= (r_src_state == S_IDLE) && src_req_i && w_full;
      r_err     <= r_err | w_src_err | w_dst_err;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign src_ack_o = r_src_ack;
  assign dst_req_o = r_dst_req;
  assign data_o    = w_rdata;
  assign count_o   = r_count;

endmodule
